// File: rtl/spi_regfile_pkg.sv
// Shared constants, phase encoding and default reset image for the SPI register file.
package spi_regfile_pkg;

    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned ADDR_W     = 7;

    localparam int unsigned REG_BACKGROUND  = 0;
    localparam int unsigned REG_SOLID_COLOR = 1;
    localparam int unsigned REG_AUDIO_EN    = 2;

    localparam logic [7:0]  RESET_REG0         = 8'h0A;
    localparam int unsigned DEFAULT_NUM_REGS   = 8;
    localparam logic [DEFAULT_NUM_REGS*8-1:0] DEFAULT_RESET_VALS =
        {{(DEFAULT_NUM_REGS-1){8'h00}}, RESET_REG0};

    typedef enum logic {
        PH_CMD,
        PH_DATA
    } phase_e;

endpackage

// File: rtl/spi_regfile_if.sv
// SPI pin bundle between host (master) and the register file (slave).
interface spi_regfile_if;
    logic SSEL;
    logic MOSI;
    logic MISO;

    modport slave  (input  SSEL, input  MOSI, output MISO);
    modport master (output SSEL, output MOSI, input  MISO);
endinterface

// File: rtl/spi_frame_rx.sv
// SPI frame receiver: bit counter, byte assembly and CMD/DATA phase, cleared while SSEL is high.
module spi_frame_rx
    import spi_regfile_pkg::*;
(
    input  logic       SCLK,
    input  logic       rst_n,
    input  logic       ssel,
    input  logic       mosi,
    output logic       byte_done,
    output logic [7:0] byte_val,
    output phase_e     phase
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    phase_e     phase_q, phase_d;

    // The completing byte includes the bit on MOSI right now, so consumers act on the same edge.
    assign byte_val  = {shift_q, mosi};
    assign byte_done = !ssel && (bit_cnt_q == 3'd7);
    assign phase     = phase_q;

    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            phase_q   <= PH_CMD;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        phase_d   = phase_q;
        if (ssel) begin
            bit_cnt_d = '0;
            shift_d   = '0;
            phase_d   = PH_CMD;
        end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = byte_val[6:0];
            if (bit_cnt_q == 3'd7) begin
                phase_d = PH_DATA;
            end
        end
    end

endmodule

// File: rtl/spi_regfile.sv
// SPI-slave register bank with address-framed, auto-incrementing access and one-hot write strobes.
// Build option: define SPI_REGFILE_READBACK_EN to enable register readback on MISO.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [NUM_REGS*8-1:0] RESET_VALS = {{(NUM_REGS-1){8'h00}}, RESET_REG0}
) (
    input  logic                  SCLK,
    input  logic                  rst_n,
    spi_regfile_if.slave          spi,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic [NUM_REGS-1:0]   wr_stb
);

    logic              byte_done;
    logic [7:0]        byte_val;
    phase_e            phase;

    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cmd_addr, addr_inc;
    logic              rw_q, rw_d;
    logic              miso_q, miso_d;

    spi_frame_rx u_rx (
        .SCLK      (SCLK),
        .rst_n     (rst_n),
        .ssel      (spi.SSEL),
        .mosi      (spi.MOSI),
        .byte_done (byte_done),
        .byte_val  (byte_val),
        .phase     (phase)
    );

    assign cmd_addr = byte_val[ADDR_W-1:0];
    assign addr_inc = (addr_q == ADDR_W'(NUM_REGS-1)) ? '0 : addr_q + ADDR_W'(1);

    // Out-of-range addresses match no register, so the write and its strobe vanish naturally.
    always_comb begin
        regs_d   = regs_q;
        wr_stb_d = '0;
        addr_d   = addr_q;
        rw_d     = rw_q;
        if (byte_done) begin
            if (phase == PH_CMD) begin
                rw_d   = byte_val[CMD_RW_BIT];
                addr_d = cmd_addr;
            end else begin
                addr_d = addr_inc;
                if (!rw_q) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i)) begin
                            regs_d[i]   = byte_val;
                            wr_stb_d[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef SPI_REGFILE_READBACK_EN
    logic [7:0]        shadow_q, shadow_d;
    logic [ADDR_W-1:0] rd_addr;
    logic              load_en;
    logic [7:0]        load_val;

    // The MSB is driven on the loading edge itself; the shadow keeps only the remaining bits.
    always_comb begin
        rd_addr  = (phase == PH_CMD) ? cmd_addr : addr_inc;
        load_en  = byte_done && ((phase == PH_CMD) ? byte_val[CMD_RW_BIT] : rw_q);
        load_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                load_val = regs_q[i];
            end
        end
        miso_d   = 1'b0;
        shadow_d = shadow_q;
        if (spi.SSEL) begin
            shadow_d = '0;
        end else if (load_en) begin
            miso_d   = load_val[7];
            shadow_d = {load_val[6:0], 1'b0};
        end else begin
            miso_d   = shadow_q[7];
            shadow_d = {shadow_q[6:0], 1'b0};
        end
    end
`else
    always_comb begin
        miso_d = !spi.SSEL;
    end
`endif

    always_ff @(posedge SCLK) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALS[i*8 +: 8];
            end
            wr_stb_q <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            miso_q   <= 1'b0;
`ifdef SPI_REGFILE_READBACK_EN
            shadow_q <= '0;
`endif
        end else begin
            regs_q   <= regs_d;
            wr_stb_q <= wr_stb_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            miso_q   <= miso_d;
`ifdef SPI_REGFILE_READBACK_EN
            shadow_q <= shadow_d;
`endif
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_o[i*8 +: 8] = regs_q[i];
        end
    end

    assign wr_stb   = wr_stb_q;
    assign spi.MISO = miso_q;

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI-slave register file for the demoscene top level: a generalised successor to the fixed three-field SPI control block. The host writes and reads a bank of `NUM_REGS` 8-bit control registers (background state, solid colour, audio enable, and future effect parameters) using an address-framed protocol with auto-increment. The bank is exposed as a flat bus plus per-register write strobes to the video and audio generators. Everything runs in the SCLK domain; consumers synchronise as needed.

## Interface
- `NUM_REGS`, 8: number of 8-bit registers (2..128).
- `RESET_VALS`, `{(NUM_REGS-1){8'h00}, 8'h0A}`: flat reset image, `NUM_REGS*8` bits; register i takes bits `[8i+7:8i]`.
- `SCLK`  in  1  SPI clock (mode 0); sole clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `SSEL`  in  1  slave select, active-low; high = idle, framing reset.
- `MOSI`  in  1  serial data in, MSB first.
- `MISO`  out  1  serial data out, registered.
- `regs_o`  out  `NUM_REGS*8`  current register contents, flat.
- `wr_stb`  out  `NUM_REGS`  one-hot write strobe for the register written by the last completed byte.

## Operation
- Frame = SSEL low, then a command byte `{rw, addr[6:0]}` (rw=1 read, 0 write), then zero or more data bytes.
- Bit counter (3 b) and byte assembly run while SSEL is low; on any posedge with SSEL high they clear to 0, phase returns to CMD, and MISO is driven to 0.
- Command byte complete (bit 7): latch `rw` and `addr`. Phase goes to DATA.
- Write, each completed data byte: if `addr < NUM_REGS`, `regs_o[addr] <= byte` and `wr_stb <= 1<<addr`. Otherwise the write is ignored and `wr_stb` is 0. Then `addr <= addr+1`, wrapping `NUM_REGS-1 -> 0`.
- Read: the shadow byte is loaded with `regs[addr]`, or 0x00 if out of range, at the completion edge of the command byte and of each data byte, using the post-increment address. MISO shifts the shadow out MSB first. Bytes arriving on MOSI during a read frame are discarded.
- `wr_stb` is otherwise 0. It clears on the next SCLK posedge.
- Reset (rst_n low at a posedge), which overrides SSEL and wins mid-frame:
  - `regs_o = RESET_VALS`, `wr_stb = 0`, `MISO = 0`;
  - framing cleared to CMD, bit count 0;
  - the partially shifted byte is dropped.

## Timing
- MOSI is sampled on the SCLK posedge. MISO updates on the posedge and holds until the next one; the host samples it on the negedge.
- The first read data MSB appears at the posedge that completes the command byte. It is computed from `{shift[6:0], MOSI}`, so there is zero bit latency.
- A write is visible on `regs_o` after the posedge of the last data bit, i.e. 1 SCLK after that bit is sampled.
- `wr_stb` lasts one SCLK period. It holds indefinitely if SCLK stops, and consumers edge-detect it.
- Back-to-back bytes: the byte boundary is the bit-count wrap 7 -> 0, with no gap cycles.
- Deasserting SSEL mid-byte discards the partial byte. No register changes.

## Configuration
- `SPI_REGFILE_READBACK_EN` defined: read frames behave as above.
- Undefined:
  - the read path and shadow register are removed;
  - MISO = 1 while SSEL is low and 0 while high (legacy presence indication);
  - read frames only advance the address.

## Structure
- Package `spi_regfile_pkg`:
  - `CMD_RW_BIT = 7` and `ADDR_W = 7`;
  - register index constants `REG_BACKGROUND = 0`, `REG_SOLID_COLOR = 1`, `REG_AUDIO_EN = 2`;
  - the default reset image.
- Sub-module `spi_frame_rx`: bit counter, byte shift register, `byte_done` pulse, and CMD/DATA phase with SSEL clear.
- The register bank, address pointer, and MISO path stay in `spi_regfile`.

## Test plan
- Reset with SSEL low mid-byte:
  - `regs_o[7:0] = 0x0A` and all other registers 0;
  - `wr_stb = 0`, MISO 0;
  - the next frame decodes from the command byte.
- Write frame `0x01, 0x2A` (NUM_REGS=8) -> register 1 = 0x2A and `wr_stb = 8'b0000_0010` for exactly one SCLK; all other registers unchanged.
- Burst write `0x06, 0x11, 0x22, 0x33` -> reg6 = 0x11, reg7 = 0x22, reg0 = 0x33 (wrap); three one-hot strobes in sequence.
- Read frame `0x81` after the write above, with `READBACK_EN` defined -> MISO bits during data byte 1 are 0x2A MSB first, and the next byte returns reg2.
- Write `0x7F, 0x55` (out of range) -> no register change and `wr_stb` stays 0. Read `0xFF` -> MISO returns 0x00.
- SSEL raised after 4 bits of a data byte -> no write and no strobe. The next frame restarts at CMD. Repeat the read test with the macro undefined -> MISO is held at 1 while SSEL is low.
